// File: rtl/rv_exec_alu_pkg.sv
// rv_exec_alu shared definitions
// Op-code constants, widths and the queued result bundle.
package rv_exec_alu_pkg;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    // {funct7[5], funct3}
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            carry;
        logic            illegal;
    } alu_res_t;

endpackage

// File: rtl/rv_exec_alu_core.sv
// rv_exec_alu_core: combinational RV32I ALU
// Shared adder (add/sub/compare) and a 5-stage barrel shifter.
module rv_exec_alu_core
    import rv_exec_alu_pkg::*;
(
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            carry,
    output logic            illegal
);

    logic            sub;
    logic [XLEN-1:0] b_add;
    logic [XLEN:0]   sum;
    logic            lt_s;
    logic            lt_u;
    logic [4:0]      shamt;
    logic [XLEN-1:0] sl [6];
    logic [XLEN-1:0] sr [6];
    logic [XLEN-1:0] sra_fill;

    // Adder: subtract for SUB and both compares (a + ~b + 1)
    always_comb begin
        sub   = (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
        b_add = sub ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_add} + {{XLEN{1'b0}}, sub};
        lt_u  = ~sum[XLEN];
        lt_s  = (a[XLEN-1] != b[XLEN-1]) ? a[XLEN-1] : sum[XLEN-1];
    end

    // Barrel shifter: one stage per shamt bit, left and right
    always_comb begin
        shamt = b[4:0];
        sl[0] = a;
        sr[0] = a;
        for (int i = 0; i < 5; i++) begin
            sl[i+1] = shamt[i] ? (sl[i] << (2 ** i)) : sl[i];
            sr[i+1] = shamt[i] ? (sr[i] >> (2 ** i)) : sr[i];
        end
        sra_fill = a[XLEN-1] ? ~({XLEN{1'b1}} >> shamt) : '0;
    end

    // Op-code to result mapping; undefined codes flag illegal
    always_comb begin
        result  = '0;
        carry   = 1'b0;
        illegal = 1'b0;
        case (op)
            ALU_ADD: begin
                result = sum[XLEN-1:0];
                carry  = sum[XLEN];
            end
            ALU_SUB: begin
                result = sum[XLEN-1:0];
                carry  = sum[XLEN];
            end
            ALU_SLL:  result = sl[5];
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = sr[5];
            ALU_SRA:  result = sr[5] | sra_fill;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv_exec_alu.sv
// rv_exec_alu: RV32I execute stage
// ALU core feeding a 2-entry result queue with registered head.
module rv_exec_alu
    import rv_exec_alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_carry,
    output logic            out_illegal
);

    alu_res_t   new_res;
    alu_res_t   mem_q [DEPTH];
    alu_res_t   mem_d [DEPTH];
    alu_res_t   head_q;
    alu_res_t   head_d;
    logic       rd_ptr_q;
    logic       rd_ptr_d;
    logic       wr_ptr_q;
    logic       wr_ptr_d;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       push;
    logic       pop;

    rv_exec_alu_core u_core (
        .op      (in_op),
        .a       (in_a),
        .b       (in_b),
        .result  (new_res.result),
        .carry   (new_res.carry),
        .illegal (new_res.illegal)
    );

    assign new_res.rd = in_rd;

    // Handshake flags come from registered count only
    assign in_ready  = (count_q < 2'(DEPTH));
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_result  = head_q.result;
    assign out_rd      = head_q.rd;
    assign out_carry   = head_q.carry;
    assign out_illegal = head_q.illegal;

    // Next queue state; head reloads only when a result remains
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_res;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        head_d  = (count_d != 2'd0) ? mem_d[rd_ptr_d] : head_q;
    end

    // Queue and head registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q   <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            head_q   <= head_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_rv_exec_alu.sv
// tb_rv_exec_alu: scoreboard bench for rv_exec_alu
// Directed vectors, back-pressure, reset flush and streaming.
module tb_rv_exec_alu;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        carry;
        logic        illegal;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_carry;
    logic        out_illegal;

    exp_t exp_q [$];
    int   n_vec;
    int   n_fail;

    rv_exec_alu dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_carry   (out_carry),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every consumed head against the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got result=%h rd=%0d, required none",
                         out_result, out_rd);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_result !== e.result || out_rd !== e.rd ||
                    out_carry !== e.carry || out_illegal !== e.illegal) begin
                    n_fail++;
                    $display("FAIL sb: got r=%h rd=%0d c=%b i=%b, required r=%h rd=%0d c=%b i=%b",
                             out_result, out_rd, out_carry, out_illegal,
                             e.result, e.rd, e.carry, e.illegal);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] r, input logic c, input logic il);
        exp_t e;
        int   waited;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        e.result  = r;
        e.rd      = rd;
        e.carry   = c;
        e.illegal = il;
        exp_q.push_back(e);
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain();
        int waited;
        in_valid = 1'b0;
        waited   = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            tick();
            waited++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic void model(input logic [3:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic c,
                                  output logic il);
        logic [32:0] s;
        r  = 32'd0;
        c  = 1'b0;
        il = 1'b0;
        case (op)
            4'b0000: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
            end
            4'b1000: begin
                r = a - b;
                c = (a >= b);
            end
            4'b0001: r = a << b[4:0];
            4'b0010: r = {31'd0, ($signed(a) < $signed(b))};
            4'b0011: r = {31'd0, (a < b)};
            4'b0100: r = a ^ b;
            4'b0101: r = a >> b[4:0];
            4'b1101: r = $signed(a) >>> b[4:0];
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            default: il = 1'b1;
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        logic        c;
        logic        il;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        n_vec     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 4'd0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_rd     = 5'd0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_rd", {27'd0, out_rd}, 32'd0);
        check("rst_out_flags", {30'd0, out_carry, out_illegal}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // Directed vectors
        send(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 5'd1, 32'h0000_0000, 1'b1, 1'b0);
        send(4'b1000, 32'd5, 32'd7, 5'd2, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send(4'b0010, 32'h8000_0000, 32'd1, 5'd3, 32'd1, 1'b0, 1'b0);
        send(4'b0011, 32'h8000_0000, 32'd1, 5'd4, 32'd0, 1'b0, 1'b0);
        send(4'b1101, 32'h8000_0000, 32'h0000_0024, 5'd5, 32'hF800_0000, 1'b0, 1'b0);
        send(4'b0101, 32'h8000_0000, 32'h0000_0024, 5'd6, 32'h0800_0000, 1'b0, 1'b0);
        send(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17, 32'd0, 1'b0, 1'b1);
        send(4'b0101, 32'hDEAD_BEEF, 32'd0, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b0);
        send(4'b1000, 32'd9, 32'd9, 5'd8, 32'd0, 1'b1, 1'b0);
        send(4'b0001, 32'd1, 32'd31, 5'd9, 32'h8000_0000, 1'b0, 1'b0);
        drain();
        idle(2);
        check("empty_valid", {31'd0, out_valid}, 32'd0);
        check("empty_hold", out_result, 32'h8000_0000);

        // Back-pressure: two accepts fill the queue, third waits
        out_ready = 1'b0;
        send(4'b0110, 32'hF0F0_0000, 32'h0000_0F0F, 5'd10, 32'hF0F0_0F0F, 1'b0, 1'b0);
        send(4'b0111, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd11, 32'h0F00_0F00, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_op    = 4'b0100;
        in_a     = 32'hAAAA_AAAA;
        in_b     = 32'hFFFF_0000;
        in_rd    = 5'd12;
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        check("full_in_ready2", {31'd0, in_ready}, 32'd0);
        check("full_head_hold", out_result, 32'hF0F0_0F0F);
        out_ready = 1'b1;
        tick();
        check("bp_reopen", {31'd0, in_ready}, 32'd1);
        send(4'b0100, 32'hAAAA_AAAA, 32'hFFFF_0000, 5'd12, 32'h5555_AAAA, 1'b0, 1'b0);
        drain();

        // Reset with two queued results discards them
        out_ready = 1'b0;
        send(4'b0000, 32'd1, 32'd2, 5'd13, 32'd3, 1'b0, 1'b0);
        send(4'b0000, 32'd3, 32'd4, 5'd14, 32'd7, 1'b0, 1'b0);
        idle(1);
        check("pre_rst_full", {30'd0, in_ready, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_result", out_result, 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        idle(3);
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);

        // Streaming with out_ready held high
        for (int i = 0; i < 1000; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom();
            b  = $urandom();
            if (i % 7 == 0) a = 32'h8000_0000;
            if (i % 11 == 0) b = 32'hFFFF_FFFF;
            model(op, a, b, r, c, il);
            check("stream_ready", {31'd0, in_ready}, 32'd1);
            send(op, a, b, 5'($urandom_range(0, 31)), r, c, il);
        end
        drain();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
